// File: rtl/and_gate_axi_lite_slave_if.sv
// AXI4-Lite bus bundle between the master BFM and the AND-gate register slave.
interface and_gate_axi_lite_slave_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 4
);
  logic [ADDR_W-1:0]   awaddr;
  logic [2:0]          awprot;
  logic                awvalid;
  logic                awready;
  logic [DATA_W-1:0]   wdata;
  logic [DATA_W/8-1:0] wstrb;
  logic                wvalid;
  logic                wready;
  logic [1:0]          bresp;
  logic                bvalid;
  logic                bready;
  logic [ADDR_W-1:0]   araddr;
  logic [2:0]          arprot;
  logic                arvalid;
  logic                arready;
  logic [DATA_W-1:0]   rdata;
  logic [1:0]          rresp;
  logic                rvalid;
  logic                rready;

  modport slave (
    input  awaddr, awprot, awvalid, output awready,
    input  wdata, wstrb, wvalid,    output wready,
    output bresp, bvalid,           input  bready,
    input  araddr, arprot, arvalid, output arready,
    output rdata, rresp, rvalid,    input  rready
  );

  modport master (
    output awaddr, awprot, awvalid, input  awready,
    output wdata, wstrb, wvalid,    input  wready,
    input  bresp, bvalid,           output bready,
    output araddr, arprot, arvalid, input  arready,
    input  rdata, rresp, rvalid,    output rready
  );
endinterface

// File: rtl/and_gate_axi_lite_slave.sv
// AXI4-Lite slave with four RW registers and a registered reg0 & reg1 output.
module and_gate_axi_lite_slave #(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 4
) (
  input  logic                          s00_axi_aclk,
  input  logic                          s00_axi_aresetn,
  and_gate_axi_lite_slave_if.slave      s00_axi,
  output logic [C_S_AXI_DATA_WIDTH-1:0] and_out
);
  localparam int NB = C_S_AXI_DATA_WIDTH / 8;

  logic [3:0][NB-1:0][7:0]       r_regs;
  logic [C_S_AXI_DATA_WIDTH-1:0] r_and;
  logic [C_S_AXI_DATA_WIDTH-1:0] r_rdata;
  logic                          r_awready, r_wready, r_bvalid;
  logic                          r_arready, r_rvalid;

  logic       w_wr_start, w_wr_en, w_rd_start, w_rd_en;
  logic [1:0] w_wsel, w_rsel;
  logic       w_unused;

  // Ready is raised only once both AW and W are present; the handshake edge
  // that follows commits the data and raises bvalid.
  assign w_wr_start = s00_axi.awvalid & s00_axi.wvalid & ~r_awready & ~r_bvalid;
  assign w_wr_en    = r_awready & s00_axi.awvalid & r_wready & s00_axi.wvalid;
  assign w_rd_start = s00_axi.arvalid & ~r_arready & ~r_rvalid;
  assign w_rd_en    = r_arready & s00_axi.arvalid;
  assign w_wsel     = s00_axi.awaddr[3:2];
  assign w_rsel     = s00_axi.araddr[3:2];
  assign w_unused   = &{s00_axi.awprot, s00_axi.arprot,
                        s00_axi.awaddr[1:0], s00_axi.araddr[1:0]};

  always_ff @(posedge s00_axi_aclk) begin
    if (!s00_axi_aresetn) begin
      r_awready <= 1'b0;
      r_wready  <= 1'b0;
      r_bvalid  <= 1'b0;
      r_regs    <= '0;
    end else begin
      r_awready <= w_wr_start;
      r_wready  <= w_wr_start;
      if (w_wr_en)                        r_bvalid <= 1'b1;
      else if (r_bvalid && s00_axi.bready) r_bvalid <= 1'b0;
      for (int b = 0; b < NB; b++)
        if (w_wr_en && s00_axi.wstrb[b]) r_regs[w_wsel][b] <= s00_axi.wdata[b*8 +: 8];
    end
  end

  // rdata samples the register array with NBAs, so a same-edge write is not seen.
  always_ff @(posedge s00_axi_aclk) begin
    if (!s00_axi_aresetn) begin
      r_arready <= 1'b0;
      r_rvalid  <= 1'b0;
      r_rdata   <= '0;
      r_and     <= '0;
    end else begin
      r_arready <= w_rd_start;
      if (w_rd_en) begin
        r_rvalid <= 1'b1;
        r_rdata  <= r_regs[w_rsel];
      end else if (r_rvalid && s00_axi.rready) begin
        r_rvalid <= 1'b0;
      end
      r_and <= r_regs[0] & r_regs[1];
    end
  end

  assign s00_axi.awready = r_awready;
  assign s00_axi.wready  = r_wready;
  assign s00_axi.bvalid  = r_bvalid;
  assign s00_axi.bresp   = 2'b00;
  assign s00_axi.arready = r_arready;
  assign s00_axi.rvalid  = r_rvalid;
  assign s00_axi.rdata   = r_rdata;
  assign s00_axi.rresp   = 2'b00;
  assign and_out         = r_and;
endmodule

// File: tb/tb_and_gate_axi_lite_slave.sv
// Directed bench for and_gate_axi_lite_slave: register RW, strobes, split AW/W,
// backpressure, mid-read reset and address aliasing.
module tb_and_gate_axi_lite_slave;
  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic [31:0] and_out;
  int          n_asrt = 0;
  int          n_fail = 0;

  and_gate_axi_lite_slave_if #(.DATA_W(32), .ADDR_W(4)) bus ();

  and_gate_axi_lite_slave #(.C_S_AXI_DATA_WIDTH(32), .C_S_AXI_ADDR_WIDTH(4)) dut (
    .s00_axi_aclk    (clk),
    .s00_axi_aresetn (rstn),
    .s00_axi         (bus),
    .and_out         (and_out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asrt++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic axi_write(input logic [3:0] a, input logic [31:0] d, input logic [3:0] s,
                           input string tag);
    int cyc;
    bus.awaddr = a; bus.wdata = d; bus.wstrb = s;
    bus.awvalid = 1'b1; bus.wvalid = 1'b1;
    cyc = 0;
    do begin step(); cyc++; end while (!bus.awready && cyc < 20);
    chk({tag, "_awready"}, 32'(bus.awready), 32'd1);
    step();
    bus.awvalid = 1'b0; bus.wvalid = 1'b0;
    chk({tag, "_bvalid"}, 32'(bus.bvalid), 32'd1);
    chk({tag, "_bresp"}, 32'(bus.bresp), 32'd0);
    step();
    chk({tag, "_bclr"}, 32'(bus.bvalid), 32'd0);
  endtask

  task automatic axi_read(input logic [7:0] a, input logic [31:0] exp, input string tag);
    int cyc;
    bus.araddr = a[3:0]; bus.arvalid = 1'b1;
    cyc = 0;
    do begin step(); cyc++; end while (!bus.arready && cyc < 20);
    chk({tag, "_arready"}, 32'(bus.arready), 32'd1);
    step();
    bus.arvalid = 1'b0;
    chk({tag, "_rvalid"}, 32'(bus.rvalid), 32'd1);
    chk({tag, "_rresp"}, 32'(bus.rresp), 32'd0);
    chk({tag, "_rdata"}, bus.rdata, exp);
    step();
    chk({tag, "_rclr"}, 32'(bus.rvalid), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.awaddr = '0; bus.awprot = '0; bus.awvalid = 1'b0;
    bus.wdata = '0; bus.wstrb = '0; bus.wvalid = 1'b0; bus.bready = 1'b1;
    bus.araddr = '0; bus.arprot = '0; bus.arvalid = 1'b0; bus.rready = 1'b1;

    // reset state
    repeat (3) step();
    chk("rst_awready", 32'(bus.awready), 32'd0);
    chk("rst_wready", 32'(bus.wready), 32'd0);
    chk("rst_arready", 32'(bus.arready), 32'd0);
    chk("rst_bvalid", 32'(bus.bvalid), 32'd0);
    chk("rst_rvalid", 32'(bus.rvalid), 32'd0);
    chk("rst_rdata", bus.rdata, 32'h0);
    chk("rst_and_out", and_out, 32'h0);
    rstn = 1'b1;

    // sequential write / read-back
    axi_write(4'h0, 32'h0101FFFF, 4'hF, "wr0");
    axi_write(4'h4, 32'hABCD0001, 4'hF, "wr1");
    axi_write(4'h8, 32'hDEAD0011, 4'hF, "wr2");
    axi_write(4'hC, 32'hBEEF0011, 4'hF, "wr3");
    axi_read(8'h00, 32'h0101FFFF, "rd0");
    axi_read(8'h04, 32'hABCD0001, "rd1");
    axi_read(8'h08, 32'hDEAD0011, "rd2");
    axi_read(8'h0C, 32'hBEEF0011, "rd3");
    chk("and_seq", and_out, 32'h01010001);

    // byte strobes
    axi_write(4'h8, 32'h12345678, 4'b0101, "wr_strb");
    axi_read(8'h08, 32'hDE340078, "rd_strb");
    axi_write(4'h8, 32'hFFFFFFFF, 4'b0000, "wr_strb0");
    axi_read(8'h08, 32'hDE340078, "rd_strb0");

    // split AW / W
    bus.awaddr = 4'hC; bus.wdata = 32'h55AA55AA; bus.wstrb = 4'hF; bus.awvalid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("split_awready_wait", 32'(bus.awready), 32'd0);
      chk("split_wready_wait", 32'(bus.wready), 32'd0);
    end
    bus.wvalid = 1'b1;
    step();
    chk("split_awready", 32'(bus.awready), 32'd1);
    chk("split_wready", 32'(bus.wready), 32'd1);
    step();
    bus.awvalid = 1'b0; bus.wvalid = 1'b0;
    chk("split_awready_pulse", 32'(bus.awready), 32'd0);
    chk("split_wready_pulse", 32'(bus.wready), 32'd0);
    chk("split_bvalid", 32'(bus.bvalid), 32'd1);
    step();
    chk("split_bclr", 32'(bus.bvalid), 32'd0);
    axi_read(8'h0C, 32'h55AA55AA, "rd_split");

    // backpressure with simultaneous read and write of reg1
    bus.bready = 1'b0; bus.rready = 1'b0;
    bus.awaddr = 4'h4; bus.wdata = 32'h0; bus.wstrb = 4'hF;
    bus.awvalid = 1'b1; bus.wvalid = 1'b1;
    bus.araddr = 4'h4; bus.arvalid = 1'b1;
    step();
    chk("bp_awready", 32'(bus.awready), 32'd1);
    chk("bp_arready", 32'(bus.arready), 32'd1);
    step();
    bus.awaddr = 4'h8; bus.araddr = 4'h8;
    chk("bp_bvalid", 32'(bus.bvalid), 32'd1);
    chk("bp_rvalid", 32'(bus.rvalid), 32'd1);
    chk("bp_rdata_old", bus.rdata, 32'hABCD0001);
    for (int i = 0; i < 5; i++) begin
      step();
      chk("bp_bvalid_hold", 32'(bus.bvalid), 32'd1);
      chk("bp_rvalid_hold", 32'(bus.rvalid), 32'd1);
      chk("bp_rdata_hold", bus.rdata, 32'hABCD0001);
      chk("bp_no_aw", 32'(bus.awready), 32'd0);
      chk("bp_no_ar", 32'(bus.arready), 32'd0);
    end
    bus.awvalid = 1'b0; bus.wvalid = 1'b0; bus.arvalid = 1'b0;
    bus.bready = 1'b1; bus.rready = 1'b1;
    step();
    chk("bp_bclr", 32'(bus.bvalid), 32'd0);
    chk("bp_rclr", 32'(bus.rvalid), 32'd0);
    axi_read(8'h04, 32'h0, "rd_bp_new");
    chk("and_bp", and_out, 32'h0);

    // reset while rvalid pending
    axi_write(4'h4, 32'hFFFFFFFF, 4'hF, "wr1_ones");
    step();
    chk("and_ones", and_out, 32'h0101FFFF);
    bus.rready = 1'b0; bus.araddr = 4'h0; bus.arvalid = 1'b1;
    step();
    step();
    bus.arvalid = 1'b0;
    chk("mr_rvalid", 32'(bus.rvalid), 32'd1);
    chk("mr_rdata", bus.rdata, 32'h0101FFFF);
    rstn = 1'b0;
    step();
    chk("mr_rvalid_drop", 32'(bus.rvalid), 32'd0);
    chk("mr_and_out", and_out, 32'h0);
    chk("mr_rdata_clr", bus.rdata, 32'h0);
    rstn = 1'b1; bus.rready = 1'b1;
    axi_read(8'h00, 32'h0, "mr_reg0");
    axi_read(8'h04, 32'h0, "mr_reg1");
    axi_read(8'h08, 32'h0, "mr_reg2");
    axi_read(8'h0C, 32'h0, "mr_reg3");

    // address aliasing
    axi_write(4'h0, 32'h11111111, 4'hF, "wr_al0");
    axi_write(4'h4, 32'h22222222, 4'hF, "wr_al1");
    axi_read(8'h10, 32'h11111111, "rd_alias_10");
    axi_read(8'h07, 32'h22222222, "rd_alias_07");
    chk("and_alias", and_out, 32'h00000000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
    $finish;
  end
endmodule

// File: doc/and_gate_axi_lite_slave.md
# and_gate_axi_lite_slave

AXI4-Lite slave holding four 32-bit read/write registers, plus a registered bitwise AND of register 0 and register 1 driven to fabric. It sits directly downstream of the AXI4-Lite master BFM in the block-design wrapper. It is the target of the write/read-back test sequence at `S00_AXI_SLAVE_ADDRESS` + 0x0/0x4/0x8/0xC. All responses are OKAY.

## Interface
- `C_S_AXI_DATA_WIDTH`, default 32: data bus width. Only 32 is supported.
- `C_S_AXI_ADDR_WIDTH`, default 4: byte address width. Bits [3:2] select the register; all other bits are ignored.
- `s00_axi_aclk`, in, 1: single clock for all logic.
- `s00_axi_aresetn`, in, 1: reset, synchronous, active-low.
- `s00_axi_awaddr` in `C_S_AXI_ADDR_WIDTH`; `s00_axi_awprot` in 3 (ignored); `s00_axi_awvalid` in 1; `s00_axi_awready` out 1: write address channel.
- `s00_axi_wdata` in 32; `s00_axi_wstrb` in 4; `s00_axi_wvalid` in 1; `s00_axi_wready` out 1: write data channel.
- `s00_axi_bresp` out 2; `s00_axi_bvalid` out 1; `s00_axi_bready` in 1: write response channel.
- `s00_axi_araddr` in `C_S_AXI_ADDR_WIDTH`; `s00_axi_arprot` in 3 (ignored); `s00_axi_arvalid` in 1; `s00_axi_arready` out 1: read address channel.
- `s00_axi_rdata` out 32; `s00_axi_rresp` out 2; `s00_axi_rvalid` out 1; `s00_axi_rready` in 1: read data channel.
- `and_out`, out, 32: registered result of reg0 & reg1.

## Operation
- Register map:
  - 0x0 = reg0
  - 0x4 = reg1
  - 0x8 = reg2
  - 0xC = reg3
  - All registers are RW, reset to 0. A read returns the last written value.
- Write accept:
  - Requires `awvalid` and `wvalid` both high, `awready` low and `bvalid` low.
  - When these hold, `awready` and `wready` pulse high together for exactly one cycle.
  - Address and data are consumed on that edge.
  - A master presenting only one of AW/W waits; nothing is latched.
- Write commit:
  - On the accept edge, the selected register is updated per byte.
  - Byte n is written iff `wstrb[n]` = 1. Unselected bytes keep their old value.
  - `wstrb` = 0 leaves the register unchanged but still completes with OKAY.
- Write response:
  - `bvalid` rises the cycle after accept, with `bresp` = 00.
  - `bvalid` holds until sampled with `bready` high, then clears next edge.
  - No new write is accepted while `bvalid` is high.
- Read accept:
  - Requires `arvalid` high, `arready` low and `rvalid` low.
  - When these hold, `arready` pulses high for one cycle, and `araddr[3:2]` is decoded on that edge.
- Read response:
  - `rvalid` rises the cycle after accept.
  - `rdata` = selected register value as of the accept edge (pre-write value if a write to the same register commits on the same edge). `rresp` = 00.
  - `rvalid` and `rdata` are held stable until `rready` is sampled high.
  - No new read is accepted while `rvalid` is high.
- Read and write channels are fully independent and may accept on the same cycle.
- `and_out` is registered `reg0 & reg1`, updated every cycle. It reflects a write one cycle after commit.

## Timing
- Reset (`s00_axi_aresetn` = 0 at a rising edge):
  - Next edge: all registers, `and_out`, `awready`, `wready`, `arready`, `bvalid`, `rvalid` = 0; `bresp` = `rresp` = 00; `rdata` = 0.
  - Reset mid-transaction drops pending `bvalid`/`rvalid` with no response issued.
  - The first accept is possible on the first edge with reset high.
- Write latency, with `bready` held high:
  - Accept at edge N.
  - `bvalid` high after edge N+1, cleared at edge N+2.
  - Minimum 3 cycles per write.
- Read latency, with `rready` held high:
  - Accept at edge N.
  - `rvalid` high after edge N+1, cleared at edge N+2.
  - Minimum 3 cycles per read.
- Back-to-back operation: a new accept is allowed on the edge where `bvalid`/`rvalid` clears only if that signal was already low when sampled. Therefore one idle cycle minimum occurs between same-channel transactions.
- Backpressure: `bready`/`rready` held low for K cycles extends the response by exactly K cycles, with outputs stable throughout.

## Test plan
- Sequential RW: write then read back at 0x0/0x4/0x8/0xC with 0x0101FFFF, 0xABCD0001, 0xDEAD0011, 0xBEEF0011. Required: every read matches, all `bresp`/`rresp` = 00, `and_out` = 0x0101FFFF & 0xABCD0001 = 0x01010001.
- Byte strobes: reg2 = 0xDEAD0011, then write 0x12345678 with `wstrb` = 4'b0101. Required: read 0xDE340078; `wstrb` = 0 leaves the register unchanged with OKAY.
- Split AW/W: `awvalid` asserted 3 cycles before `wvalid`. Required: no `awready` until both are high; then a single-cycle `awready`/`wready` and a correct commit.
- Backpressure plus same-cycle RW: hold `bready`/`rready` low 5 cycles. Required: `bvalid`/`rvalid`/`rdata` stable, no second accept. A simultaneous read and write of reg1 (old 0xABCD0001, new 0x0) returns 0xABCD0001.
- Reset mid-operation: assert reset while `rvalid` is high. Required: next edge `rvalid` = 0, all registers read 0, `and_out` = 0.
- Address aliasing: read at 0x10 returns reg0; read at 0x7 returns reg1.
